sisc_ctrl_mc: RTL and testbench
===============================

Name: sisc_ctrl_mc

Overview:
- Multi-cycle SISC control FSM, next generation.
- Adds memory wait-state handshakes for instruction fetch and data access, plus an optional memory timeout.
- Adds a two-pass SWP writeback, a real HALT state in place of a simulation stop, and early return to FETCH for NOOP and branches.
- Drives the same datapath controls (RF, ALU, mux selects, IR, PC, data memory); the condition-code width is parametrised.

Parameters:
- STAT_W, 4: width of the mm condition field and of stat.
- IMM_MM, 4'b1000: mm code selecting immediate/indirect mode for ALU, LOD and STR.
- MEM_TIMEOUT, 0: max cycles to wait for mem_rdy; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; MEM_TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- opcode  in  4  instr[31:28].
- mm  in  STAT_W  instr[27:24].
- stat  in  STAT_W  status register output.
- mem_rdy  in  1  memory completes the current fetch or data access this cycle.
- im_req  out  1  instruction fetch request.
- dm_req  out  1  data memory request.
- dm_we  out  1  data memory write enable.
- rf_we  out  1  register file write enable.
- alu_op  out  2  bit1 = do not save status; bit0 = use immediate.
- wb_sel  out  1  1 = memory data to RF, 0 = ALU result.
- br_sel  out  1  1 = absolute branch target, 0 = relative.
- rb_sel  out  1  read-port B register select.
- mm_sel  out  1  1 = address from instr[15:0].
- swp_sel  out  1  SWP pass select (0 = first pass, 1 = second pass).
- ir_load  out  1  load IR.
- pc_sel  out  1  1 = branch target, 0 = PC+1.
- pc_write  out  1  PC write enable.
- pc_rst  out  1  PC reset.
- halted  out  1  FSM is in HALT.
- err  out  1  sticky memory-timeout flag.
- state  out  3  current state, for debug.

Behaviour:
- Reset:
  - With rst=1 at a clk edge: state<=START, err<=0, timeout counter<=0.
  - Outputs are combinational from state/opcode/mm/stat/mem_rdy.
  - In START: pc_rst=1 and all other outputs 0, except alu_op=2'b10.
  - Reset wins over any in-flight access, including mid-HALT or mid-wait.
- Default in every state: every output 0, except alu_op=2'b10.
- States: START=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, WB2=6, HALT=7.
- START: always goes to FETCH.
- FETCH:
  - im_req=1.
  - When mem_rdy=1: ir_load=1, pc_write=1, pc_sel=0, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - rb_sel=1 for LOD, or for ALU(8) with mm==IMM_MM.
  - Branches: BRA=4, BRR=5, BNE=6, BNR=7.
  - hit = |(mm & stat).
  - taken = hit for BRA/BRR; taken = !hit for BNE/BNR. BNE/BNR with mm=0 is therefore unconditional; BRA/BRR with mm=0 is never taken.
  - br_sel=1 for BRA/BNE, 0 for BRR/BNR.
  - pc_sel=taken, pc_write=taken.
  - Next state:
    - NOOP(0), branches, and undefined opcodes (treated as NOOP) go to FETCH.
    - HLT(15) goes to HALT.
    - All others go to EXECUTE.
- EXECUTE:
  - ALU: alu_op=01 if mm==IMM_MM, else 00.
  - LOD/STR: alu_op=11 if mm==0, else 10; mm_sel=(mm==0).
  - Next state: ALU and SWP go to WRITEBACK; LOD and STR go to MEM.
- MEM:
  - alu_op and mm_sel are held at their EXECUTE values so the address stays stable.
  - dm_req=1; dm_we=1 for STR; wb_sel=1 for LOD.
  - Waits until mem_rdy=1, then LOD goes to WRITEBACK and STR goes to FETCH.
- WRITEBACK:
  - ALU: rf_we=1.
  - LOD: rf_we=1, wb_sel=1.
  - SWP(3): rf_we=1, swp_sel=0, rb_sel=1.
  - Next state: SWP goes to WB2; all others go to FETCH.
- WB2: rf_we=1, swp_sel=1, then go to FETCH.
- HALT: halted=1, all other outputs 0; exits only via rst.
- Timeout:
  - When MEM_TIMEOUT>0, the counter increments each cycle spent in FETCH or MEM with mem_rdy=0.
  - The counter clears on any state change.
  - When the counter equals MEM_TIMEOUT and mem_rdy=0: go to HALT and set err<=1.
  - When MEM_TIMEOUT=0 the counter never increments and the FSM never times out.
- Latency with mem_rdy held at 1, counted FETCH through return to FETCH:
  - NOOP/branch: 2 cycles.
  - ALU: 4 cycles.
  - STR: 4 cycles.
  - LOD: 5 cycles.
  - SWP: 5 cycles.
- mem_rdy outside FETCH and MEM is ignored.
- opcode, mm and stat are assumed stable from DECODE through the end of the instruction; IR is loaded only in FETCH.

Test Plan:
- rst=1 for 2 cycles, then 0, mem_rdy=1 -> state START with pc_rst=1; FETCH on the first cycle after release; ir_load=pc_write=1 in FETCH.
- ALU ADD (opcode 8, mm 0) -> sequence F,D,E,W; alu_op=00 in EXECUTE; rf_we=1 only in WRITEBACK; 4 cycles.
- BNE mm=0, then BRA mm=4'b0010 with stat=4'b0010, then BRA mm=4'b0001 with stat=0:
  - first two: pc_sel=pc_write=1 in DECODE; br_sel=1.
  - third: pc_write=0.
  - all three: next state FETCH.
- LOD mm=0 with mem_rdy low 3 cycles in MEM:
  - alu_op=11, mm_sel=1 held in MEM with dm_req=1 and wb_sel=1 for 4 cycles.
  - then WRITEBACK with rf_we=1, wb_sel=1.
- SWP -> WRITEBACK with rf_we=1, swp_sel=0; then WB2 with rf_we=1, swp_sel=1; then FETCH.
- MEM_TIMEOUT=5, STR with mem_rdy=0 forever -> state reaches HALT, err=1, halted=1; dm_we=0 in HALT; stays in HALT until rst=1, which clears err.

Source files
------------

// File: rtl/sisc_ctrl_mc.sv
// sisc_ctrl_mc -- multi-cycle SISC control FSM with memory wait states.
//
// Sequences one instruction at a time through START/FETCH/DECODE/EXECUTE/
// MEM/WRITEBACK/WB2/HALT. Instruction fetch and data accesses stall until
// mem_rdy; an optional timeout parks the FSM in HALT with a sticky err flag.
// NOOP, branches and undefined opcodes return to FETCH straight from DECODE.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   opcode, mm, stat  instruction fields and status register
//   mem_rdy           memory completes current fetch/data access
//   im_req, dm_req, dm_we           memory handshakes
//   rf_we, alu_op, wb_sel, br_sel, rb_sel, mm_sel, swp_sel,
//   ir_load, pc_sel, pc_write, pc_rst  datapath controls
//   halted, err, state                 status/debug
module sisc_ctrl_mc #(
  parameter int                STAT_W      = 4,
  parameter logic [STAT_W-1:0] IMM_MM      = 4'b1000,
  parameter int                MEM_TIMEOUT = 0,
  parameter int                TO_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic [STAT_W-1:0] mm,
  input  logic [STAT_W-1:0] stat,
  input  logic              mem_rdy,
  output logic              im_req,
  output logic              dm_req,
  output logic              dm_we,
  output logic              rf_we,
  output logic [1:0]        alu_op,
  output logic              wb_sel,
  output logic              br_sel,
  output logic              rb_sel,
  output logic              mm_sel,
  output logic              swp_sel,
  output logic              ir_load,
  output logic              pc_sel,
  output logic              pc_write,
  output logic              pc_rst,
  output logic              halted,
  output logic              err,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_START = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
    S_MEM   = 3'd4, S_WB    = 3'd5, S_WB2    = 3'd6, S_HALT    = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWP  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);
  localparam bit              TO_EN  = (MEM_TIMEOUT != 0);

  state_t          state_q, state_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic is_imm, mm_zero, hit, taken, waiting, timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_START;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    im_req   = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    rf_we    = 1'b0;
    alu_op   = 2'b10;
    wb_sel   = 1'b0;
    br_sel   = 1'b0;
    rb_sel   = 1'b0;
    mm_sel   = 1'b0;
    swp_sel  = 1'b0;
    ir_load  = 1'b0;
    pc_sel   = 1'b0;
    pc_write = 1'b0;
    pc_rst   = 1'b0;
    halted   = 1'b0;
    state_d  = state_q;
    err_d    = err_q;
    taken    = 1'b0;

    is_imm      = (mm == IMM_MM);
    mm_zero     = (mm == '0);
    hit         = |(mm & stat);
    waiting     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_rdy;
    timeout_hit = TO_EN && waiting && (to_cnt_q == TO_LIM);

    unique case (state_q)
      S_START: begin
        pc_rst  = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        im_req = 1'b1;
        if (mem_rdy) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        rb_sel = (opcode == OP_LOD) || ((opcode == OP_ALU) && is_imm);
        case (opcode)
          OP_BRA, OP_BRR: taken = hit;
          OP_BNE, OP_BNR: taken = !hit;
          default:        taken = 1'b0;
        endcase
        br_sel   = (opcode == OP_BRA) || (opcode == OP_BNE);
        pc_sel   = taken;
        pc_write = taken;
        case (opcode)
          OP_LOD, OP_STR, OP_SWP, OP_ALU: state_d = S_EXECUTE;
          OP_HLT:                         state_d = S_HALT;
          default:                        state_d = S_FETCH;
        endcase
      end
      S_EXECUTE: begin
        case (opcode)
          OP_ALU: begin
            alu_op  = is_imm ? 2'b01 : 2'b00;
            state_d = S_WB;
          end
          OP_SWP: state_d = S_WB;
          OP_LOD, OP_STR: begin
            alu_op  = mm_zero ? 2'b11 : 2'b10;
            mm_sel  = mm_zero;
            state_d = S_MEM;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        // Address path controls repeat EXECUTE so the address holds during wait.
        alu_op = mm_zero ? 2'b11 : 2'b10;
        mm_sel = mm_zero;
        dm_req = 1'b1;
        dm_we  = (opcode == OP_STR);
        wb_sel = (opcode == OP_LOD);
        if (mem_rdy) begin
          state_d = (opcode == OP_LOD) ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        case (opcode)
          OP_ALU: rf_we = 1'b1;
          OP_LOD: begin
            rf_we  = 1'b1;
            wb_sel = 1'b1;
          end
          OP_SWP: begin
            rf_we  = 1'b1;
            rb_sel = 1'b1;
          end
          default: ;
        endcase
        state_d = (opcode == OP_SWP) ? S_WB2 : S_FETCH;
      end
      S_WB2: begin
        rf_we   = 1'b1;
        swp_sel = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        alu_op = 2'b00;
        halted = 1'b1;
      end
      default: state_d = S_START;
    endcase

    // Wait counter restarts whenever the FSM moves on.
    if (state_d != state_q)     to_cnt_d = '0;
    else if (TO_EN && waiting)  to_cnt_d = to_cnt_q + 1'b1;
    else                        to_cnt_d = to_cnt_q;
  end

  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
module tb_sisc_ctrl_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode, mm, stat;
  logic       mem_rdy;
  logic       im_req, dm_req, dm_we, rf_we, wb_sel, br_sel, rb_sel, mm_sel;
  logic       swp_sel, ir_load, pc_sel, pc_write, pc_rst, halted, err;
  logic [1:0] alu_op;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [2:0] ST = 3'd0, F = 3'd1, D = 3'd2, E = 3'd3, M = 3'd4,
                         W = 3'd5, W2 = 3'd6, H = 3'd7;

  always #5 clk = ~clk;

  sisc_ctrl_mc #(.STAT_W(4), .IMM_MM(4'b1000), .MEM_TIMEOUT(5), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mm(mm), .stat(stat),
    .mem_rdy(mem_rdy), .im_req(im_req), .dm_req(dm_req), .dm_we(dm_we),
    .rf_we(rf_we), .alu_op(alu_op), .wb_sel(wb_sel), .br_sel(br_sel),
    .rb_sel(rb_sel), .mm_sel(mm_sel), .swp_sel(swp_sel), .ir_load(ir_load),
    .pc_sel(pc_sel), .pc_write(pc_write), .pc_rst(pc_rst), .halted(halted),
    .err(err), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy(input logic r);
    mem_rdy = r;
    #1;
  endtask

  task automatic load(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s);
    opcode = op;
    mm     = m;
    stat   = s;
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 4'd0; mm = 4'd0; stat = 4'd0; mem_rdy = 1'b1;
    tick(); tick();
    chk("rst_state", state, ST);
    chk("rst_pc_rst", pc_rst, 1);
    chk("rst_alu_op", alu_op, 2'b10);
    chk("rst_im_req", im_req, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();
    chk("fetch_state", state, F);
    chk("fetch_im_req", im_req, 1);
    chk("fetch_ir_load", ir_load, 1);
    chk("fetch_pc_write", pc_write, 1);
    chk("fetch_pc_sel", pc_sel, 0);
    chk("fetch_pc_rst", pc_rst, 0);

    // ALU ADD, register mode: F,D,E,W then FETCH
    load(4'd8, 4'd0, 4'd0);
    tick(); chk("add_D", state, D); chk("add_D_rb", rb_sel, 0); chk("add_D_rfwe", rf_we, 0);
    tick(); chk("add_E", state, E); chk("add_E_alu", alu_op, 2'b00); chk("add_E_rfwe", rf_we, 0);
    tick(); chk("add_W", state, W); chk("add_W_rfwe", rf_we, 1); chk("add_W_wb", wb_sel, 0);
    tick(); chk("add_done", state, F); chk("add_F_rfwe", rf_we, 0);

    // ALU immediate
    load(4'd8, 4'b1000, 4'd0);
    tick(); chk("addi_D_rb", rb_sel, 1);
    tick(); chk("addi_E_alu", alu_op, 2'b01);
    tick(); tick(); chk("addi_done", state, F);

    // BNE mm=0: unconditional
    load(4'd6, 4'd0, 4'd0);
    tick(); chk("bne_D", state, D); chk("bne_pc_sel", pc_sel, 1);
    chk("bne_pc_write", pc_write, 1); chk("bne_br_sel", br_sel, 1);
    tick(); chk("bne_next", state, F);
    // BRA hit
    load(4'd4, 4'b0010, 4'b0010);
    tick(); chk("bra_hit_pc_sel", pc_sel, 1); chk("bra_hit_pc_write", pc_write, 1);
    chk("bra_hit_br_sel", br_sel, 1);
    tick(); chk("bra_hit_next", state, F);
    // BRA miss
    load(4'd4, 4'b0001, 4'd0);
    tick(); chk("bra_miss_pc_write", pc_write, 0); chk("bra_miss_pc_sel", pc_sel, 0);
    tick(); chk("bra_miss_next", state, F);
    // BNR with hit: not taken, relative
    load(4'd7, 4'b0010, 4'b0110);
    tick(); chk("bnr_pc_write", pc_write, 0); chk("bnr_br_sel", br_sel, 0);
    tick(); chk("bnr_next", state, F);
    // Undefined opcode behaves as NOOP
    load(4'd10, 4'd0, 4'd0);
    tick(); chk("undef_D", state, D);
    tick(); chk("undef_next", state, F);

    // Fetch wait: no IR load while mem_rdy low
    set_rdy(1'b0);
    chk("fwait_ir_load", ir_load, 0); chk("fwait_im_req", im_req, 1);
    tick(); chk("fwait_state", state, F);
    set_rdy(1'b1);

    // LOD mm=0 with 3 wait cycles in MEM
    load(4'd1, 4'd0, 4'd0);
    tick(); chk("lod_D_rb", rb_sel, 1);
    tick(); chk("lod_E", state, E); chk("lod_E_alu", alu_op, 2'b11); chk("lod_E_mmsel", mm_sel, 1);
    set_rdy(1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_rdy(i == 3);
      chk("lod_M_state", state, M);
      chk("lod_M_alu", alu_op, 2'b11);
      chk("lod_M_mmsel", mm_sel, 1);
      chk("lod_M_dmreq", dm_req, 1);
      chk("lod_M_wbsel", wb_sel, 1);
      chk("lod_M_dmwe", dm_we, 0);
      tick();
    end
    chk("lod_W", state, W); chk("lod_W_rfwe", rf_we, 1); chk("lod_W_wbsel", wb_sel, 1);
    tick(); chk("lod_done", state, F);

    // SWP two-pass writeback
    load(4'd3, 4'd0, 4'd0);
    tick(); chk("swp_D", state, D);
    tick(); chk("swp_E", state, E); chk("swp_E_alu", alu_op, 2'b10);
    tick(); chk("swp_W", state, W); chk("swp_W_rfwe", rf_we, 1);
    chk("swp_W_swpsel", swp_sel, 0); chk("swp_W_rb", rb_sel, 1);
    tick(); chk("swp_W2", state, W2); chk("swp_W2_rfwe", rf_we, 1); chk("swp_W2_swpsel", swp_sel, 1);
    tick(); chk("swp_done", state, F);

    // STR mm!=0, no wait: 4 cycles
    load(4'd2, 4'd5, 4'd0);
    tick(); chk("str_D_rb", rb_sel, 0);
    tick(); chk("str_E_alu", alu_op, 2'b10); chk("str_E_mmsel", mm_sel, 0);
    tick(); chk("str_M", state, M); chk("str_M_dmwe", dm_we, 1);
    chk("str_M_dmreq", dm_req, 1); chk("str_M_wbsel", wb_sel, 0);
    tick(); chk("str_done", state, F);

    // STR with 5 wait cycles: just under the timeout limit
    tick(); tick(); set_rdy(1'b0); tick();
    for (int i = 0; i < 5; i++) tick();
    chk("str_slow_M", state, M);
    set_rdy(1'b1);
    tick(); chk("str_slow_done", state, F); chk("str_slow_err", err, 0);

    // STR with mem_rdy stuck low: times out into HALT
    tick(); tick(); set_rdy(1'b0); tick();
    for (int i = 0; i < 5; i++) tick();
    chk("to_still_M", state, M); chk("to_err_pre", err, 0);
    tick();
    chk("to_halt", state, H); chk("to_err", err, 1); chk("to_halted", halted, 1);
    chk("to_dmwe", dm_we, 0); chk("to_dmreq", dm_req, 0);
    set_rdy(1'b1);
    tick(); tick(); chk("halt_stays", state, H);
    rst = 1'b1;
    tick(); chk("halt_rst_state", state, ST); chk("halt_rst_err", err, 0); chk("halt_rst_halted", halted, 0);
    rst = 1'b0;
    tick(); chk("post_rst_fetch", state, F);

    // HLT opcode
    load(4'd15, 4'd0, 4'd0);
    tick(); chk("hlt_D", state, D);
    tick(); chk("hlt_H", state, H); chk("hlt_err", err, 0); chk("hlt_halted", halted, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
